// File: rtl/seq_alu.sv
// seq_alu: multi-cycle add/mul/mod/and ALU with valid/ready handshakes; ports clk, rst_n, in_valid/in_ready, a, b, op, out_valid/out_ready, result, err (only with SEQ_ALU_DIVZERO_EN)
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
`ifdef SEQ_ALU_DIVZERO_EN
  ,
  output logic               err
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] ADD = 2'd0, MUL = 2'd1, MOD = 2'd2, AND = 2'd3;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [2*WIDTH-1:0] y_q, y_d, acc_q, acc_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_nx;
`ifdef SEQ_ALU_DIVZERO_EN
  logic               err_q, err_d;
  assign err = err_q;
`endif
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = state_q == DONE;
  assign result    = acc_q;
  // x holds the multiplier (shifted right) or the dividend (shifted left into the remainder)
  assign rem_sh = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
  assign rem_nx = rem_sh >= {1'b0, y_q[WIDTH-1:0]} ? WIDTH'(rem_sh - {1'b0, y_q[WIDTH-1:0]}) : rem_sh[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
`ifdef SEQ_ALU_DIVZERO_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        op_d    = op;
        x_d     = a;
        y_d     = {{WIDTH{1'b0}}, b};
        cnt_d   = CW'(WIDTH);
        state_d = (op == MUL || op == MOD) ? BUSY : DONE;
        acc_d   = op == ADD ? {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b} :
                  op == AND ? {{WIDTH{1'b0}}, a & b} : '0;
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = op_q == MUL ? acc_q + (x_q[0] ? y_q : '0) : {{WIDTH{1'b0}}, rem_nx};
        x_d   = op_q == MUL ? x_q >> 1 : x_q << 1;
        y_d   = op_q == MUL ? y_q << 1 : y_q;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
`ifdef SEQ_ALU_DIVZERO_EN
          err_d   = op_q == MOD && y_q == '0;
`endif
        end
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
`ifdef SEQ_ALU_DIVZERO_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
`ifdef SEQ_ALU_DIVZERO_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
`ifdef SEQ_ALU_DIVZERO_EN
      err_q   <= err_d;
`endif
    end
  end
endmodule
